keypad_entry: RTL and testbench
===============================

KEYPAD_ENTRY -- requirements
Module: keypad_entry

Interface
REQ-001 SHALL have parameter DIGITS, default 4: max digits per entry, legal range 1..4.
REQ-002 SHALL have parameter TIMEOUT, default 1000: idle cycles before a partial entry is discarded, minimum 2.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset (low = reset).
REQ-005 SHALL have port key_valid  input  1  a key is presented this cycle.
REQ-006 SHALL have port key_code  input  4  key value: 0-9 digit, 10 CLEAR, 11 BACKSPACE, 12 ENTER, 13 SET, 14-15 reserved.
REQ-007 SHALL have port key_ready  output  1  block can accept a key this cycle.
REQ-008 SHALL have port password_input  output  16  binary value of the committed entry, feeds the downstream lock.
REQ-009 SHALL have port enter  output  1  one-cycle pulse: attempt unlock with password_input.
REQ-010 SHALL have port reset_pwd  output  1  one-cycle pulse: store password_input as the new password.
REQ-011 SHALL have port digit_count  output  3  number of digits currently buffered.
REQ-012 SHALL have port entry_error  output  1  one-cycle pulse on a rejected key or a timeout.

Function
REQ-013 SHALL accept a key only on a rising edge where key_valid and key_ready are both 1; key_code SHALL be ignored otherwise.
REQ-014 SHALL implement states IDLE (0 digits), ENTRY (1..DIGITS digits) and CONVERT; key_ready SHALL be 1 in IDLE and ENTRY and 0 in CONVERT.
REQ-015 SHALL handle a digit as follows: if digit_count < DIGITS, push it onto a digit buffer (newest last) and increment digit_count; otherwise discard it, pulse entry_error and leave digit_count unchanged.
REQ-016 SHALL handle BACKSPACE as follows: remove the newest digit and decrement digit_count; with 0 digits, pulse entry_error.
REQ-017 SHALL handle CLEAR as follows: empty the buffer and return to IDLE, with no error pulse.
REQ-018 SHALL handle ENTER or SET with n >= 1 digits by moving to CONVERT, latching the key type and clearing the accumulator.
REQ-019 SHALL handle ENTER or SET with 0 digits by pulsing entry_error, with no enter/reset_pwd pulse.
REQ-020 SHALL, in CONVERT, process one digit per cycle, oldest first, with acc = acc*10 + digit, using 16-bit arithmetic (max 9999, no overflow).
REQ-021 SHALL, on the edge that processes the n-th digit: load password_input with the final value, assert enter (ENTER) or reset_pwd (SET) for exactly one cycle, empty the buffer and return to IDLE.
REQ-022 SHALL assert the enter or reset_pwd pulse on the n-th rising edge after the edge that accepted the commit key.
REQ-023 SHALL hold password_input stable from the pulse until the next commit completes.
REQ-024 SHALL never assert enter and reset_pwd in the same cycle.
REQ-025 SHALL implement the timeout as follows: in ENTRY, a counter resets on every accepted key; after TIMEOUT consecutive cycles with no accepted key, the block SHALL empty the buffer, return to IDLE and pulse entry_error. The counter SHALL be inactive in IDLE and CONVERT.
REQ-026 SHALL treat reserved codes 14-15 as accepted-and-ignored keys: entry_error pulse, no state change, timeout counter restarted.
REQ-027 SHALL accept a key presented in the same cycle as an output pulse (the state is already IDLE).

Reset
REQ-028 SHALL, while rst = 0, immediately force: state IDLE, buffer empty, digit_count 0, password_input 0, enter 0, reset_pwd 0, entry_error 0, key_ready 1, timeout counter 0.
REQ-029 SHALL, if rst is asserted mid-CONVERT, abort the conversion with no pulse, both during reset and after its release.

Verification
REQ-030 SHALL be verified by a bench covering: assert rst=0 during activity -> all outputs 0, key_ready 1; after release, keys 1,2,3,4,ENTER -> enter high one cycle, 4 edges after ENTER is accepted, password_input=1234 (0x04D2), held afterwards.
REQ-031 SHALL be verified by a bench covering: keys 5,6,7,8,SET -> reset_pwd pulse, password_input=5678, enter stays 0; key_ready 0 for exactly 4 cycles.
REQ-032 SHALL be verified by a bench covering: keys 1,2,9,BACKSPACE,1,5,ENTER -> password_input=1215; and BACKSPACE on an empty buffer -> entry_error pulse only.
REQ-033 SHALL be verified by a bench covering: keys 1,2,3,4,5 -> the 5th key gives an entry_error pulse, digit_count stays 4; ENTER -> 1234. ENTER with 0 digits -> entry_error, no enter.
REQ-034 SHALL be verified by a bench covering: with TIMEOUT=16, keys 7,3 then 16 idle cycles -> digit_count 0, entry_error pulse; then 9,ENTER -> password_input=9. A key accepted at idle cycle 15 restarts the count.
REQ-035 SHALL be verified by a bench covering: rst pulsed low during the CONVERT of 4,3,2,1,ENTER -> no enter pulse, password_input 0, digit_count 0.

Source files
------------

// File: rtl/keypad_entry_if.sv
// Key handshake and committed-entry outputs between a keypad source and keypad_entry.
interface keypad_entry_if;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_ready;
  logic [15:0] password_input;
  logic        enter;
  logic        reset_pwd;
  logic [2:0]  digit_count;
  logic        entry_error;

  modport master (
    output key_valid, key_code,
    input  key_ready, password_input, enter, reset_pwd, digit_count, entry_error
  );

  modport slave (
    input  key_valid, key_code,
    output key_ready, password_input, enter, reset_pwd, digit_count, entry_error
  );
endinterface

// File: rtl/keypad_entry.sv
// Buffers keypad digits and, on ENTER/SET, converts them to binary one digit per cycle
// before pulsing enter or reset_pwd towards the lock.
module keypad_entry #(
  parameter int DIGITS  = 4,
  parameter int TIMEOUT = 1000
) (
  input  logic           clk,
  input  logic           rst,
  keypad_entry_if.slave  kp
);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int TW = $clog2(TIMEOUT);

  localparam logic [3:0] K_CLR = 4'd10;
  localparam logic [3:0] K_BSP = 4'd11;
  localparam logic [3:0] K_ENT = 4'd12;
  localparam logic [3:0] K_SET = 4'd13;

  typedef enum logic [1:0] {IDLE, ENTRY, CONVERT} state_t;

  state_t                 state;
  logic [DIGITS-1:0][3:0] dbuf;
  logic [2:0]             cnt;
  logic [IW-1:0]          idx;
  logic [15:0]            acc, acc_nxt, pwd;
  logic                   is_set, enter_q, set_q, err_q;
  logic [TW-1:0]          tmr;
  logic                   take;

  assign take              = kp.key_valid && kp.key_ready;
  assign kp.key_ready      = (state != CONVERT);
  assign kp.digit_count    = cnt;
  assign kp.password_input = pwd;
  assign kp.enter          = enter_q;
  assign kp.reset_pwd      = set_q;
  assign kp.entry_error    = err_q;

  // dbuf[0] is the oldest digit, so conversion walks idx upwards.
  assign acc_nxt = acc * 16'd10 + {12'd0, dbuf[idx]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      dbuf    <= '0;
      cnt     <= '0;
      idx     <= '0;
      acc     <= '0;
      pwd     <= '0;
      is_set  <= 1'b0;
      enter_q <= 1'b0;
      set_q   <= 1'b0;
      err_q   <= 1'b0;
      tmr     <= '0;
    end else begin
      enter_q <= 1'b0;
      set_q   <= 1'b0;
      err_q   <= 1'b0;
      case (state)
        IDLE, ENTRY: begin
          if (take) begin
            tmr <= '0;
            if (kp.key_code < 4'd10) begin
              if (cnt < 3'(DIGITS)) begin
                dbuf[cnt[IW-1:0]] <= kp.key_code;
                cnt               <= cnt + 3'd1;
                state             <= ENTRY;
              end else begin
                err_q <= 1'b1;
              end
            end else begin
              case (kp.key_code)
                K_CLR: begin
                  cnt   <= '0;
                  state <= IDLE;
                end
                K_BSP: begin
                  if (cnt == 3'd0) err_q <= 1'b1;
                  else begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1) state <= IDLE;
                  end
                end
                K_ENT, K_SET: begin
                  if (cnt == 3'd0) err_q <= 1'b1;
                  else begin
                    state  <= CONVERT;
                    is_set <= (kp.key_code == K_SET);
                    acc    <= '0;
                    idx    <= '0;
                  end
                end
                default: err_q <= 1'b1;
              endcase
            end
          end else if (state == ENTRY) begin
            // tmr counts idle edges since the last accepted key
            if (tmr == TW'(TIMEOUT - 1)) begin
              tmr   <= '0;
              cnt   <= '0;
              state <= IDLE;
              err_q <= 1'b1;
            end else begin
              tmr <= tmr + TW'(1);
            end
          end
        end
        CONVERT: begin
          acc <= acc_nxt;
          idx <= idx + IW'(1);
          if ((3'(idx) + 3'd1) == cnt) begin
            pwd     <= acc_nxt;
            enter_q <= !is_set;
            set_q   <= is_set;
            cnt     <= '0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_keypad_entry.sv
// Randomized plus directed bench for keypad_entry with a digit-queue reference model and pulse scoreboard.
module tb_keypad_entry;
  localparam int DIGITS  = 4;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  keypad_entry_if kp();
  keypad_entry #(.DIGITS(DIGITS), .TIMEOUT(TIMEOUT)) dut (.clk(clk), .rst(rst), .kp(kp));

  // kind: 0 enter, 1 reset_pwd, 2 entry_error
  typedef struct { int kind; int val; } ev_t;
  ev_t         sb[$];
  int          mq[$];
  int          idle_n = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  logic [15:0] exp_pwd = 16'd0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void push_ev(input int kind, input int val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    sb.push_back(e);
  endfunction

  // Reference model: a list of digits, evaluated in decimal on commit.
  function automatic void model_key(input int c);
    int v;
    idle_n = 0;
    if (c <= 9) begin
      if (mq.size() < DIGITS) mq.push_back(c);
      else push_ev(2, 0);
    end else if (c == 10) begin
      mq.delete();
    end else if (c == 11) begin
      if (mq.size() == 0) push_ev(2, 0);
      else void'(mq.pop_back());
    end else if (c == 12 || c == 13) begin
      if (mq.size() == 0) push_ev(2, 0);
      else begin
        v = 0;
        foreach (mq[i]) v = v * 10 + mq[i];
        push_ev(c == 12 ? 0 : 1, v);
        mq.delete();
      end
    end else begin
      push_ev(2, 0);
    end
  endfunction

  function automatic void model_idle();
    if (mq.size() > 0) begin
      idle_n++;
      if (idle_n == TIMEOUT) begin
        push_ev(2, 0);
        mq.delete();
        idle_n = 0;
      end
    end
  endfunction

  // Monitor: pops one expected event per output pulse, else checks password hold.
  initial begin
    int  np, k;
    ev_t e;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        np = int'(kp.enter) + int'(kp.reset_pwd) + int'(kp.entry_error);
        k  = kp.enter ? 0 : (kp.reset_pwd ? 1 : 2);
        if (np > 1) chk("pulse_exclusive", np, 1);
        else if (np == 1) begin
          if (sb.size() == 0) chk("unexpected_pulse", k, -1);
          else begin
            e = sb.pop_front();
            chk("pulse_kind", k, e.kind);
            if (e.kind != 2) begin
              chk("pwd_value", int'(kp.password_input), e.val);
              exp_pwd = 16'(e.val);
            end
          end
        end else begin
          chk("pwd_hold", int'(kp.password_input), int'(exp_pwd));
        end
      end
    end
  end

  // Called at a negedge; presents one key (or an idle cycle) and returns at the next negedge.
  task automatic cycle(input bit v, input logic [3:0] c);
    int w = 0;
    while (v && !kp.key_ready && w < 2 * DIGITS + 4) begin
      @(negedge clk);
      w++;
    end
    if (v && !kp.key_ready) begin
      chk("key_ready_wait", 0, 1);
      return;
    end
    if (kp.key_ready) chk("digit_count", int'(kp.digit_count), mq.size());
    kp.key_valid = v;
    kp.key_code  = c;
    if (v) model_key(int'(c));
    else model_idle();
    @(negedge clk);
    kp.key_valid = 1'b0;
    kp.key_code  = 4'd0;
  endtask

  task automatic keys(input int n, input int k0, input int k1, input int k2,
                      input int k3, input int k4, input int k5, input int k6);
    int ks[7];
    ks = '{k0, k1, k2, k3, k4, k5, k6};
    for (int i = 0; i < n; i++) cycle(1'b1, 4'(ks[i]));
  endtask

  // Called right after a commit key; latency in edges and key_ready-low cycle count.
  task automatic measure(output int lat, output int low);
    lat = -1;
    low = kp.key_ready ? 0 : 1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if ((kp.enter || kp.reset_pwd) && lat < 0) lat = k;
      if (!kp.key_ready) low++;
    end
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_pwd"}, int'(kp.password_input), 0);
    chk({tag, "_enter"}, int'(kp.enter), 0);
    chk({tag, "_reset_pwd"}, int'(kp.reset_pwd), 0);
    chk({tag, "_error"}, int'(kp.entry_error), 0);
    chk({tag, "_count"}, int'(kp.digit_count), 0);
    chk({tag, "_ready"}, int'(kp.key_ready), 1);
  endtask

  task automatic apply_reset(input string tag);
    rst = 1'b0;
    sb.delete();
    mq.delete();
    idle_n  = 0;
    exp_pwd = 16'd0;
    #1;
    check_reset_outputs(tag);
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs({tag, "_hold"});
    rst = 1'b1;
  endtask

  initial begin
    int lat, low, r;
    kp.key_valid = 1'b0;
    kp.key_code  = 4'd0;
    #12;
    check_reset_outputs("por");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // reset during activity with digits buffered
    keys(2, 5, 6, 0, 0, 0, 0, 0);
    apply_reset("rst_active");
    @(negedge clk);

    // 1234 ENTER: latency and hold
    keys(5, 1, 2, 3, 4, 12, 0, 0);
    measure(lat, low);
    chk("enter_latency", lat, 4);
    chk("pwd_1234", int'(kp.password_input), 16'h04D2);
    repeat (3) cycle(1'b0, 4'd0);
    chk("pwd_1234_held", int'(kp.password_input), 1234);

    // 5678 SET: reset_pwd pulse, key_ready low 4 cycles
    keys(5, 5, 6, 7, 8, 13, 0, 0);
    measure(lat, low);
    chk("set_latency", lat, 4);
    chk("set_ready_low", low, 4);
    chk("pwd_5678", int'(kp.password_input), 5678);

    // backspace edits and empty-buffer backspace
    keys(7, 1, 2, 9, 11, 1, 5, 12);
    measure(lat, low);
    chk("pwd_1215", int'(kp.password_input), 1215);
    cycle(1'b1, 4'd11);

    // overflow digit, then commit; then empty commit
    keys(5, 1, 2, 3, 4, 5, 0, 0);
    chk("overflow_count", int'(kp.digit_count), 4);
    cycle(1'b1, 4'd12);
    measure(lat, low);
    chk("pwd_1234_again", int'(kp.password_input), 1234);
    cycle(1'b1, 4'd12);
    repeat (3) cycle(1'b0, 4'd0);

    // timeout after 16 idle cycles, then 9 ENTER
    keys(2, 7, 3, 0, 0, 0, 0, 0);
    repeat (TIMEOUT - 1) cycle(1'b0, 4'd0);
    chk("pre_timeout_count", int'(kp.digit_count), 2);
    cycle(1'b0, 4'd0);
    chk("timeout_count", int'(kp.digit_count), 0);
    keys(2, 9, 12, 0, 0, 0, 0, 0);
    measure(lat, low);
    chk("pwd_9", int'(kp.password_input), 9);

    // key at idle cycle 15 restarts the count
    cycle(1'b1, 4'd7);
    repeat (TIMEOUT - 2) cycle(1'b0, 4'd0);
    cycle(1'b1, 4'd3);
    repeat (TIMEOUT - 1) cycle(1'b0, 4'd0);
    chk("restart_count", int'(kp.digit_count), 2);
    cycle(1'b0, 4'd0);
    chk("restart_timeout", int'(kp.digit_count), 0);

    // reserved codes
    cycle(1'b1, 4'd14);
    keys(2, 8, 15, 0, 0, 0, 0, 0);
    chk("reserved_count", int'(kp.digit_count), 1);
    cycle(1'b1, 4'd10);

    // reset mid-CONVERT aborts the pulse
    keys(5, 4, 3, 2, 1, 12, 0, 0);
    @(negedge clk);
    apply_reset("rst_convert");
    repeat (8) cycle(1'b0, 4'd0);
    chk("abort_pwd", int'(kp.password_input), 0);
    chk("abort_count", int'(kp.digit_count), 0);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 45)      cycle(1'b1, 4'($urandom_range(0, 9)));
      else if (r < 55) cycle(1'b1, 4'($urandom_range(12, 13)));
      else if (r < 64) cycle(1'b1, 4'd11);
      else if (r < 67) cycle(1'b1, 4'd10);
      else if (r < 70) cycle(1'b1, 4'($urandom_range(14, 15)));
      else if (r < 72) repeat (TIMEOUT + 2) cycle(1'b0, 4'd0);
      else             cycle(1'b0, 4'd0);
    end
    repeat (3 * DIGITS) cycle(1'b0, 4'd0);
    chk("scoreboard_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
